// File: rtl/ccm_pkg.sv
// Shared CCM definitions: FSM states, block/byte geometry, default latency and tag length.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
package ccm_pkg;

  localparam int BYTE_W         = 8;
  localparam int BLK_W          = 128;
  localparam int BLK_BYTES      = BLK_W / BYTE_W;
  localparam int DEF_TAG_BYTES  = 8;
  localparam int DEF_CIPHER_LAT = 1;

  typedef logic [BLK_W-1:0]  blk_t;
  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    B0,
    COLLECT,
    CIPHER,
    TAG_OUT
  } ccm_state_e;

  // Byte idx of a block, byte 0 being the most significant.
  function automatic byte_t blk_get_byte(input blk_t b, input logic [3:0] idx);
    blk_t sh;
    sh = b << {idx, 3'b000};
    return sh[BLK_W-1 -: BYTE_W];
  endfunction

  // OR byte d into position idx (byte 0 = MSB); the target byte must already be zero.
  function automatic blk_t blk_put_byte(input blk_t b, input byte_t d, input logic [3:0] idx);
    return b | (blk_t'(d) << {~idx, 3'b000});
  endfunction

endpackage

// File: rtl/ccm_cipher_stub.sv
// Interim block cipher (data XOR key) behind a fixed-latency wrapper, shared with the CTR stage.
// Latency: CIPHER_LAT cycles from in_dat to the consumer's capture register (CIPHER_LAT-1 internal stages).
// Backpressure: none; free-running pipeline, the consumer times its capture with a counter.
// Ports: clk, reset (sync, active-high); key, in_dat (block inputs); out_dat (block result).
module ccm_cipher_stub
  import ccm_pkg::*;
#(
  parameter int CIPHER_LAT = DEF_CIPHER_LAT
) (
  input  logic clk,
  input  logic reset,
  input  blk_t key,
  input  blk_t in_dat,
  output blk_t out_dat
);

  generate
    if (CIPHER_LAT == 1) begin : g_comb
      // The consumer's own register is the single stage of latency.
      logic unused_clk_rst;
      assign unused_clk_rst = clk | reset;
      assign out_dat = in_dat ^ key;
    end else begin : g_pipe
      blk_t stage [0:CIPHER_LAT-2];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < CIPHER_LAT - 1; i++) stage[i] <= '0;
        end else begin
          stage[0] <= in_dat ^ key;
          for (int i = 1; i < CIPHER_LAT - 1; i++) stage[i] <= stage[i-1];
        end
      end

      assign out_dat = stage[CIPHER_LAT-2];
    end
  endgenerate

endmodule

// File: rtl/ccm_cbc_mac.sv
// CCM authentication: CBC-MAC over B0 and a byte-serial message, tag streamed out MSB-first.
// Latency: CIPHER_LAT cycles per block pass; first tag byte CIPHER_LAT+1 cycles after the last byte.
// Backpressure: in_ready low outside COLLECT (bytes offered then are dropped); tag stream has none.
// Ports: clk, reset (sync, active-high); key_aes, b0, b0_only, start (job setup);
//        in_data/in_valid/in_last/in_ready (message bytes); s0 (encrypted counter block 0);
//        tag_data/tag_valid/tag_last (tag stream); busy (not IDLE).
// Build option: CCM_CBC_MAC_TAG_ENC_EN defined emits U = T XOR S0; undefined emits raw T, s0 unused.
module ccm_cbc_mac
  import ccm_pkg::*;
#(
  parameter int WIDTH       = BYTE_W,
  parameter int WIDTH_BLOCK = BLK_W,
  parameter int CIPHER_LAT  = DEF_CIPHER_LAT,
  parameter int TAG_BYTES   = DEF_TAG_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH_BLOCK-1:0] key_aes,
  input  logic [WIDTH_BLOCK-1:0] b0,
  input  logic                   b0_only,
  input  logic                   start,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic [WIDTH_BLOCK-1:0] s0,
  output logic [WIDTH-1:0]       tag_data,
  output logic                   tag_valid,
  output logic                   tag_last,
  output logic                   busy
);

  localparam logic [3:0] LAT_M1       = 4'(CIPHER_LAT - 1);
  localparam logic [4:0] TAG_LAST_IDX = 5'(TAG_BYTES - 1);

  ccm_state_e state;
  logic [3:0] lat_cnt;     // cycles left in the current cipher pass
  logic [3:0] byte_cnt;    // next byte slot in the block being filled
  logic [4:0] tag_idx;     // next tag byte to load into tag_data
  logic       fin_q;       // the pass in flight is the final one (b0_only, or block held in_last)
  blk_t       x;           // CBC chain value
  blk_t       blk;         // message block under construction, unfilled bytes zero
  blk_t       cipher_in;
  blk_t       cipher_out;
  blk_t       blk_merged;
  blk_t       tag_blk;
  logic [3:0] tag_sel;
  byte_t      tag_byte_nxt;

  ccm_cipher_stub #(
    .CIPHER_LAT(CIPHER_LAT)
  ) u_cipher (
    .clk    (clk),
    .reset  (reset),
    .key    (key_aes),
    .in_dat (cipher_in),
    .out_dat(cipher_out)
  );

  assign blk_merged = blk_put_byte(blk, in_data, byte_cnt);

  // Byte 0 is taken straight from the cipher result on the edge that enters TAG_OUT,
  // so the first tag byte appears in the same cycle X becomes valid.
  always_comb begin
    tag_blk = x;
    tag_sel = tag_idx[3:0];
    if (state != TAG_OUT) begin
      tag_blk = cipher_out;
      tag_sel = 4'd0;
    end
`ifdef CCM_CBC_MAC_TAG_ENC_EN
    tag_byte_nxt = blk_get_byte(tag_blk, tag_sel) ^ blk_get_byte(s0, tag_sel);
`else
    tag_byte_nxt = blk_get_byte(tag_blk, tag_sel);
`endif
  end

`ifndef CCM_CBC_MAC_TAG_ENC_EN
  logic unused_s0;
  assign unused_s0 = ^s0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      byte_cnt  <= '0;
      tag_idx   <= '0;
      fin_q     <= 1'b0;
      x         <= '0;
      blk       <= '0;
      cipher_in <= '0;
      in_ready  <= 1'b0;
      tag_data  <= '0;
      tag_valid <= 1'b0;
      tag_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cipher_in <= b0;   // X starts at zero, so X ^ B0 is B0 itself
            fin_q     <= b0_only;
            x         <= '0;
            blk       <= '0;
            byte_cnt  <= '0;
            lat_cnt   <= LAT_M1;
            busy      <= 1'b1;
            state     <= B0;
          end
        end

        B0, CIPHER: begin
          if (lat_cnt == 4'd0) begin
            x <= cipher_out;
            if (fin_q) begin
              tag_valid <= 1'b1;
              tag_data  <= tag_byte_nxt;
              tag_last  <= 1'b0;
              tag_idx   <= 5'd1;
              state     <= TAG_OUT;
            end else begin
              in_ready <= 1'b1;
              state    <= COLLECT;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end

        COLLECT: begin
          if (in_valid) begin
            if (byte_cnt == 4'd15 || in_last) begin
              cipher_in <= x ^ blk_merged;
              blk       <= '0;
              byte_cnt  <= '0;
              fin_q     <= in_last;
              lat_cnt   <= LAT_M1;
              in_ready  <= 1'b0;
              state     <= CIPHER;
            end else begin
              blk      <= blk_merged;
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end

        TAG_OUT: begin
          if (tag_last) begin
            tag_valid <= 1'b0;
            tag_last  <= 1'b0;
            tag_data  <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            tag_data <= tag_byte_nxt;
            tag_last <= (tag_idx == TAG_LAST_IDX);
            tag_idx  <= tag_idx + 5'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
